stack_seq: RTL and testbench

Stack-transfer sequencer in the memory stage of the pipelined processor. It owns the stack pointer and accepts one stack request at a time from the decode control logic: push/pop of a register, a 32-bit PC (CALL/RET), or the PC+flags frame (interrupt/RETI). It breaks each request into back-to-back 16-bit accesses on the data-memory port and returns popped PC/flags/register values as single-cycle load pulses. While a request is in flight it holds `busy` so the pipeline stalls.

---
 rtl/stack_seq_pkg.sv | 51 +++++
 rtl/stack_seq_if.sv | 38 +++
 rtl/stack_seq_sp_reg.sv | 27 ++
 rtl/stack_seq.sv | 196 +++++++++++++++++++
 tb/tb_stack_seq.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/stack_seq_pkg.sv
// Shared types and constants for the stack-transfer sequencer.
// Holds opcode/state enums, reset SP value and per-op word counts.
package stack_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int WORD_W     = 16;

  localparam logic [ADDR_W_DEF-1:0] SP_INIT_DEF = '1;

  localparam logic [1:0] N_REG = 2'd1;
  localparam logic [1:0] N_PC  = 2'd2;
  localparam logic [1:0] N_INT = 2'd3;

  typedef enum logic [2:0] {
    OP_PUSH_REG = 3'b000,
    OP_POP_REG  = 3'b001,
    OP_PUSH_PC  = 3'b010,
    OP_POP_PC   = 3'b011,
    OP_PUSH_INT = 3'b100,
    OP_POP_RETI = 3'b101
  } stack_op_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH     = 3'd1,
    POP      = 3'd2,
    POP_LAST = 3'd3,
    RESULT   = 3'd4
  } state_t;

  // Zero marks an illegal opcode.
  function automatic logic [1:0] op_words(
    input stack_op_t op
  );
    case (op)
      OP_PUSH_REG, OP_POP_REG:  return N_REG;
      OP_PUSH_PC,  OP_POP_PC:   return N_PC;
      OP_PUSH_INT, OP_POP_RETI: return N_INT;
      default:                  return 2'd0;
    endcase
  endfunction

  function automatic logic op_is_pop(
    input stack_op_t op
  );
    return (op == OP_POP_REG) ||
           (op == OP_POP_PC)  ||
           (op == OP_POP_RETI);
  endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Request handshake plus data-memory port of the stack sequencer.
// master: requester/memory side; slave: the sequencer.
interface stack_seq_if
  import stack_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  stack_op_t         req_op;
  logic [WORD_W-1:0] req_reg_data;
  logic [31:0]       req_pc;
  logic [2:0]        req_flags;

  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_op,
    output req_reg_data, req_pc,
    output req_flags, mem_rdata,
    input  req_ready, mem_addr,
    input  mem_wdata, mem_we, mem_re
  );

  modport slave (
    input  req_valid, req_op,
    input  req_reg_data, req_pc,
    input  req_flags, mem_rdata,
    output req_ready, mem_addr,
    output mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/stack_seq_sp_reg.sv
// Stack pointer register: reset to SP_INIT, modulo inc/dec.
// Ports: clk, reset (async low), inc, dec, sp.
module sp_reg #(
  parameter int                ADDR_W  = 20,
  parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp
);

  localparam logic [ADDR_W-1:0] ONE =
    {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= SP_INIT;
    end else if (inc) begin
      sp <= sp + ONE;
    end else if (dec) begin
      sp <= sp - ONE;
    end
  end

endmodule

// File: rtl/stack_seq.sv
// Stack-transfer sequencer: splits stack requests into 16-bit
// memory accesses. Ports: clk, reset, bus (req + mem), pop
// result pulses (reg/pc/flags), busy, sp.
module stack_seq
  import stack_pkg::*;
#(
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter int                DATA_W  = WORD_W,
  parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
  input  logic                clk,
  input  logic                reset,
  stack_seq_if.slave          bus,
  output logic                pop_reg_valid,
  output logic [DATA_W-1:0]   pop_reg_data,
  output logic                pc_load,
  output logic [2*DATA_W-1:0] pc_value,
  output logic                flags_load,
  output logic [2:0]          flags_value,
  output logic                busy,
  output logic [ADDR_W-1:0]   sp
);

  localparam logic [ADDR_W-1:0] ONE =
    {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t    state, state_nxt;
  stack_op_t op_q;
  logic [1:0] cnt_q;
  logic       rd_q;
  logic       accept;
  logic       sp_inc, sp_dec;

  // Push words leave from [0]; popped words enter at [2].
  logic [2:0][DATA_W-1:0] words_q;
  logic [2:0][DATA_W-1:0] push_w;
  logic [2:0][DATA_W-1:0] cap_nxt;

  sp_reg #(
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) u_sp (
    .clk   (clk),
    .reset (reset),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .sp    (sp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    sp_inc        = 1'b0;
    sp_dec        = 1'b0;
    bus.req_ready = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    busy          = 1'b1;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (bus.req_valid) begin
          accept = 1'b1;
          if (op_words(bus.req_op) == 2'd0) begin
            state_nxt = RESULT;
          end else if (op_is_pop(bus.req_op)) begin
            state_nxt = POP;
          end else begin
            state_nxt = PUSH;
          end
        end
      end
      PUSH: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = sp;
        bus.mem_wdata = words_q[0];
        sp_dec        = 1'b1;
        if (cnt_q == 2'd0) begin
          state_nxt = IDLE;
        end
      end
      POP: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = sp + ONE;
        sp_inc       = 1'b1;
        if (cnt_q == 2'd0) begin
          state_nxt = POP_LAST;
        end
      end
      POP_LAST: begin
        state_nxt = RESULT;
      end
      RESULT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    push_w = '0;
    case (bus.req_op)
      OP_PUSH_REG: begin
        push_w[0] = bus.req_reg_data;
      end
      OP_PUSH_PC: begin
        push_w[0] = bus.req_pc[31:16];
        push_w[1] = bus.req_pc[15:0];
      end
      OP_PUSH_INT: begin
        push_w[0] = bus.req_pc[31:16];
        push_w[1] = bus.req_pc[15:0];
        push_w[2] = {{(DATA_W-3){1'b0}},
                     bus.req_flags};
      end
      default: begin
        push_w = '0;
      end
    endcase
  end

  assign cap_nxt = {bus.mem_rdata,
                    words_q[2],
                    words_q[1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q          <= OP_PUSH_REG;
      cnt_q         <= 2'd0;
      rd_q          <= 1'b0;
      words_q       <= '0;
      pop_reg_valid <= 1'b0;
      pop_reg_data  <= '0;
      pc_load       <= 1'b0;
      pc_value      <= '0;
      flags_load    <= 1'b0;
      flags_value   <= '0;
    end else begin
      rd_q          <= bus.mem_re;
      pop_reg_valid <= 1'b0;
      pc_load       <= 1'b0;
      flags_load    <= 1'b0;
      if (accept) begin
        op_q    <= bus.req_op;
        cnt_q   <= op_words(bus.req_op) - 2'd1;
        words_q <= push_w;
      end else if (state == PUSH) begin
        words_q <= {{DATA_W{1'b0}},
                    words_q[2],
                    words_q[1]};
        cnt_q   <= cnt_q - 2'd1;
      end else if (state == POP) begin
        // First POP cycle has no read data yet.
        if (rd_q) begin
          words_q <= cap_nxt;
        end
        cnt_q <= cnt_q - 2'd1;
      end else if (state == POP_LAST) begin
        words_q <= cap_nxt;
        case (op_q)
          OP_POP_REG: begin
            pop_reg_valid <= 1'b1;
            pop_reg_data  <= cap_nxt[2];
          end
          OP_POP_PC: begin
            pc_load  <= 1'b1;
            pc_value <= {cap_nxt[2], cap_nxt[1]};
          end
          OP_POP_RETI: begin
            pc_load     <= 1'b1;
            pc_value    <= {cap_nxt[2], cap_nxt[1]};
            flags_load  <= 1'b1;
            flags_value <= cap_nxt[0][2:0];
          end
          default: begin
            pc_load <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Directed testbench for stack_seq with a behavioural data memory.
// Each step samples 1ns after the rising edge.
module tb_stack_seq;
  import stack_pkg::*;

  logic        clk;
  logic        reset;
  logic        pop_reg_valid;
  logic [15:0] pop_reg_data;
  logic        pc_load;
  logic [31:0] pc_value;
  logic        flags_load;
  logic [2:0]  flags_value;
  logic        busy;
  logic [19:0] sp;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [logic [19:0]];

  stack_seq_if #(.ADDR_W(20)) bus ();

  stack_seq #(.ADDR_W(20)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .pop_reg_valid (pop_reg_valid),
    .pop_reg_data  (pop_reg_data),
    .pc_load       (pc_load),
    .pc_value      (pc_value),
    .flags_load    (flags_load),
    .flags_value   (flags_value),
    .busy          (busy),
    .sp            (sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rd(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    bus.mem_rdata <= bus.mem_re ? rd(bus.mem_addr) : 16'h0000;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input stack_op_t op,
                       input logic [15:0] rdat,
                       input logic [31:0] pc,
                       input logic [2:0] fl);
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_reg_data = rdat;
    bus.req_pc       = pc;
    bus.req_flags    = fl;
  endtask

  initial begin
    reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = OP_PUSH_REG;
    bus.req_reg_data = 16'h0;
    bus.req_pc = 32'h0;
    bus.req_flags = 3'b0;
    bus.mem_rdata = 16'h0;
    mem[20'h00000] = 16'hA5A5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sp", sp, 20'hFFFFF);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_re", bus.mem_re, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_loads", {pc_load, flags_load, pop_reg_valid}, 0);
    reset = 1'b1;
    tick();

    // PUSH_PC 0x0001_2345
    issue(OP_PUSH_PC, 16'h0, 32'h0001_2345, 3'b0);
    chk("pp_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    chk("pp1", {bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata},
        {1'b1, 1'b0, 20'hFFFFF, 16'h0001});
    chk("pp1_busy", busy, 1);
    tick();
    chk("pp2", {bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata},
        {1'b1, 1'b0, 20'hFFFFE, 16'h2345});
    tick();
    chk("pp3", {bus.req_ready, bus.mem_we, sp}, {1'b1, 1'b0, 20'hFFFFD});

    // POP_PC
    issue(OP_POP_PC, 16'h0, 32'h0, 3'b0);
    tick();
    bus.req_valid = 1'b0;
    chk("pc1", {bus.mem_re, bus.mem_we, bus.mem_addr},
        {1'b1, 1'b0, 20'hFFFFE});
    tick();
    chk("pc2", {bus.mem_re, bus.mem_addr}, {1'b1, 20'hFFFFF});
    tick();
    chk("pc3", {bus.mem_re, busy, pc_load}, {1'b0, 1'b1, 1'b0});
    tick();
    chk("pc4", {pc_load, flags_load, pc_value}, {1'b1, 1'b0, 32'h0001_2345});
    tick();
    chk("pc5", {pc_load, bus.req_ready, sp}, {1'b0, 1'b1, 20'hFFFFF});

    // PUSH_INT, POP_RETI held pending
    issue(OP_PUSH_INT, 16'h0, 32'h0000_0100, 3'b101);
    tick();
    issue(OP_POP_RETI, 16'h0, 32'h0, 3'b0);
    chk("pi1", {bus.req_ready, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata},
        {1'b0, 1'b1, 1'b0, 20'hFFFFF, 16'h0000});
    tick();
    chk("pi2", {bus.req_ready, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata},
        {1'b0, 1'b1, 1'b0, 20'hFFFFE, 16'h0100});
    tick();
    chk("pi3", {bus.req_ready, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata},
        {1'b0, 1'b1, 1'b0, 20'hFFFFD, 16'h0005});
    tick();
    chk("pi4_accept", {bus.req_ready, busy, bus.mem_we, bus.mem_re, sp},
        {1'b1, 1'b0, 1'b0, 1'b0, 20'hFFFFC});
    tick();
    bus.req_valid = 1'b0;
    chk("rt1", {bus.mem_re, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 20'hFFFFD});
    tick();
    chk("rt2", {bus.mem_re, bus.mem_addr}, {1'b1, 20'hFFFFE});
    tick();
    chk("rt3", {bus.mem_re, bus.mem_addr}, {1'b1, 20'hFFFFF});
    tick();
    chk("rt4", {bus.mem_re, pc_load, flags_load}, 0);
    tick();
    chk("rt5", {flags_load, pc_load, flags_value, pc_value},
        {1'b1, 1'b1, 3'b101, 32'h0000_0100});
    tick();
    chk("rt6", {flags_load, pc_load, bus.req_ready, sp},
        {1'b0, 1'b0, 1'b1, 20'hFFFFF});

    // PUSH_REG 0xBEEF then POP_REG
    issue(OP_PUSH_REG, 16'hBEEF, 32'h0, 3'b0);
    tick();
    bus.req_valid = 1'b0;
    chk("pr1", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
        {1'b1, 20'hFFFFF, 16'hBEEF});
    tick();
    chk("pr2", {bus.req_ready, sp}, {1'b1, 20'hFFFFE});
    issue(OP_POP_REG, 16'h0, 32'h0, 3'b0);
    tick();
    bus.req_valid = 1'b0;
    chk("or1", {busy, bus.mem_re, bus.mem_addr}, {1'b1, 1'b1, 20'hFFFFF});
    tick();
    chk("or2", {busy, pop_reg_valid}, {1'b1, 1'b0});
    tick();
    chk("or3", {busy, pop_reg_valid, pop_reg_data}, {1'b1, 1'b1, 16'hBEEF});
    tick();
    chk("or4", {busy, pop_reg_valid, sp}, {1'b0, 1'b0, 20'hFFFFF});

    // illegal opcode
    issue(stack_op_t'(3'b111), 16'h0, 32'h0, 3'b0);
    tick();
    bus.req_valid = 1'b0;
    chk("il1", {busy, bus.req_ready, bus.mem_we, bus.mem_re},
        {1'b1, 1'b0, 1'b0, 1'b0});
    tick();
    chk("il2", {busy, bus.req_ready, pc_load, flags_load, pop_reg_valid, sp},
        {1'b0, 1'b1, 3'b000, 20'hFFFFF});

    // pop from reset SP wraps to address 0
    issue(OP_POP_REG, 16'h0, 32'h0, 3'b0);
    tick();
    bus.req_valid = 1'b0;
    chk("wr1", {bus.mem_re, bus.mem_addr}, {1'b1, 20'h00000});
    tick();
    tick();
    chk("wr3", {pop_reg_valid, pop_reg_data}, {1'b1, 16'hA5A5});
    tick();
    chk("wr4_sp", sp, 20'h00000);
    issue(OP_PUSH_REG, 16'h1234, 32'h0, 3'b0);
    tick();
    bus.req_valid = 1'b0;
    chk("wp1", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
        {1'b1, 20'h00000, 16'h1234});
    tick();
    chk("wp2_sp", sp, 20'hFFFFF);

    // reset in cycle 2 of PUSH_INT
    issue(OP_PUSH_INT, 16'h0, 32'hDEAD_BEEF, 3'b011);
    tick();
    bus.req_valid = 1'b0;
    chk("ab1", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
        {1'b1, 20'hFFFFF, 16'hDEAD});
    tick();
    reset = 1'b0;
    #1;
    chk("ab_mem", {bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata}, 0);
    chk("ab_ctl", {busy, bus.req_ready, sp}, {1'b0, 1'b1, 20'hFFFFF});
    chk("ab_loads", {pc_load, flags_load, pop_reg_valid, pc_value}, 0);
    chk("ab_kept", rd(20'hFFFFF), 16'hDEAD);
    reset = 1'b1;
    tick();
    chk("ab_after", {bus.req_ready, sp}, {1'b1, 20'hFFFFF});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
